// File: rtl/oam_dma_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oam_dma_arbiter_pkg                                                  |
// | Shared types, addresses and helpers for the OAM DMA bus arbiter.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package oam_dma_arbiter_pkg;

  localparam int unsigned DMA_LEN  = 160;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [15:0] DMA_REG  = 16'hFF46;
  localparam logic [15:0] HRAM_LO  = 16'hFF80;
  localparam logic [15:0] HRAM_HI  = 16'hFFFE;
  localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [7:0]  ECHO_LO  = 8'hE0;
  localparam logic [7:0]  ECHO_OFS = 8'h20;

  typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_READ, DMA_WRITE} dma_state_t;
  typedef enum logic [1:0] {RSRC_MEM, RSRC_HRAM, RSRC_DMAREG, RSRC_FF} rsrc_t;

  // Pages in the echo-RAM window fold back onto work RAM.
  function automatic logic [7:0] src_page(input logic [7:0] page);
    return (page >= ECHO_LO) ? (page - ECHO_OFS) : page;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_engine.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oam_dma_engine                                                       |
// | OAM DMA sequencer: FSM, byte index and source/destination addresses. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module oam_dma_engine
  import oam_dma_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_trigger,
  input  logic [7:0]  i_page,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_active,
  output logic        o_done,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic [7:0]  o_page
);

  dma_state_t r_state;
  dma_state_t w_state_nxt;
  logic [7:0] r_idx;
  logic [7:0] w_idx_nxt;
  logic [7:0] r_page;
  logic       r_done;
  logic       w_done_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DMA_IDLE;
      r_idx   <= 8'h00;
      r_page  <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
      if (i_trigger) begin
        r_page <= i_page;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    o_mem_addr  = 16'h0000;
    o_mem_wdata = 8'h00;
    case (r_state)
      DMA_IDLE:  w_state_nxt = DMA_IDLE;
      DMA_START: w_state_nxt = DMA_READ;
      DMA_READ: begin
        o_mem_rd    = 1'b1;
        o_mem_addr  = {src_page(r_page), r_idx};
        w_state_nxt = DMA_WRITE;
      end
      DMA_WRITE: begin
        o_mem_wr    = 1'b1;
        o_mem_addr  = OAM_BASE + {8'h00, r_idx};
        o_mem_wdata = i_mem_rdata;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = DMA_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = DMA_READ;
          w_idx_nxt   = r_idx + 8'd1;
        end
      end
      default: w_state_nxt = DMA_IDLE;
    endcase
    // A new trigger restarts from byte 0 and suppresses any completion pulse.
    if (i_trigger) begin
      w_state_nxt = DMA_START;
      w_idx_nxt   = 8'h00;
      w_done_nxt  = 1'b0;
    end
  end

  assign o_active = (r_state != DMA_IDLE);
  assign o_done   = r_done;
  assign o_page   = r_page;

endmodule
`default_nettype wire

// File: rtl/oam_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | oam_dma_arbiter                                                      |
// | Arbitrates the main memory bus between CPU and OAM DMA; HRAM and the |
// | DMA register stay reachable while DMA owns the bus.                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_cpu_addr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic        i_cpu_rd,
  input  logic        i_cpu_wr,
  output logic [7:0]  o_cpu_rdata,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  input  logic [7:0]  i_mem_rdata,
  output logic [6:0]  o_hram_addr,
  output logic [7:0]  o_hram_wdata,
  output logic        o_hram_wr,
  input  logic [7:0]  i_hram_rdata,
  output logic        o_dma_active,
  output logic        o_dma_done
);

  logic        w_is_hram;
  logic        w_is_dmareg;
  logic        w_is_bus;
  logic        w_trigger;
  logic        w_dma_active;
  logic        w_dma_rd;
  logic        w_dma_wr;
  logic [15:0] w_dma_addr;
  logic [7:0]  w_dma_wdata;
  logic [7:0]  w_page;
  rsrc_t       w_rsrc;
  logic [7:0]  w_rdata_sel;

  rsrc_t       r_rsrc;
  logic        r_rd_pend;
  logic [7:0]  r_rdata_hold;

  assign w_is_hram   = (i_cpu_addr >= HRAM_LO) && (i_cpu_addr <= HRAM_HI);
  assign w_is_dmareg = (i_cpu_addr == DMA_REG);
  assign w_is_bus    = !(w_is_hram || w_is_dmareg);
  assign w_trigger   = i_cpu_wr && w_is_dmareg;

  oam_dma_engine u_engine (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_trigger   (w_trigger),
    .i_page      (i_cpu_wdata),
    .i_mem_rdata (i_mem_rdata),
    .o_active    (w_dma_active),
    .o_done      (o_dma_done),
    .o_mem_rd    (w_dma_rd),
    .o_mem_wr    (w_dma_wr),
    .o_mem_addr  (w_dma_addr),
    .o_mem_wdata (w_dma_wdata),
    .o_page      (w_page)
  );

  // START counts as active, so the CPU is already locked out in the dead cycle.
  always_comb begin
    o_mem_addr  = 16'h0000;
    o_mem_wdata = 8'h00;
    o_mem_rd    = 1'b0;
    o_mem_wr    = 1'b0;
    if (w_dma_active) begin
      o_mem_addr  = w_dma_addr;
      o_mem_wdata = w_dma_wdata;
      o_mem_rd    = w_dma_rd;
      o_mem_wr    = w_dma_wr;
    end else if (w_is_bus) begin
      o_mem_addr  = i_cpu_addr;
      o_mem_wdata = i_cpu_wdata;
      o_mem_rd    = i_cpu_rd;
      o_mem_wr    = i_cpu_wr;
    end
  end

  assign o_hram_addr  = i_cpu_addr[6:0];
  assign o_hram_wdata = i_cpu_wdata;
  assign o_hram_wr    = i_cpu_wr && w_is_hram;
  assign o_dma_active = w_dma_active;

  always_comb begin
    if (w_is_hram) begin
      w_rsrc = RSRC_HRAM;
    end else if (w_is_dmareg) begin
      w_rsrc = RSRC_DMAREG;
    end else if (w_dma_active) begin
      w_rsrc = RSRC_FF;
    end else begin
      w_rsrc = RSRC_MEM;
    end
  end

  always_comb begin
    case (r_rsrc)
      RSRC_MEM:    w_rdata_sel = i_mem_rdata;
      RSRC_HRAM:   w_rdata_sel = i_hram_rdata;
      RSRC_DMAREG: w_rdata_sel = w_page;
      default:     w_rdata_sel = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend    <= 1'b0;
      r_rsrc       <= RSRC_MEM;
      r_rdata_hold <= 8'h00;
    end else begin
      r_rd_pend <= i_cpu_rd;
      if (i_cpu_rd) begin
        r_rsrc <= w_rsrc;
      end
      if (r_rd_pend) begin
        r_rdata_hold <= w_rdata_sel;
      end
    end
  end

  // Read data arrives combinationally from the 1-cycle memories, then is held.
  assign o_cpu_rdata = r_rd_pend ? w_rdata_sel : r_rdata_hold;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_oam_dma_arbiter                                                   |
// | Directed bench for oam_dma_arbiter with bus/HRAM memory models.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [6:0]  hram_addr;
  logic [7:0]  hram_wdata;
  logic        hram_wr;
  logic [7:0]  hram_rdata = 8'h00;
  logic        dma_active;
  logic        dma_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t evq[$];
  int  doneq[$];
  int  actq[$];

  logic [7:0] mem  [0:65535];
  logic [7:0] hram [0:127];

  oam_dma_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cpu_addr   (cpu_addr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_rd     (cpu_rd),
    .i_cpu_wr     (cpu_wr),
    .o_cpu_rdata  (cpu_rdata),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .o_mem_rd     (mem_rd),
    .o_mem_wr     (mem_wr),
    .i_mem_rdata  (mem_rdata),
    .o_hram_addr  (hram_addr),
    .o_hram_wdata (hram_wdata),
    .o_hram_wr    (hram_wr),
    .i_hram_rdata (hram_rdata),
    .o_dma_active (dma_active),
    .o_dma_done   (dma_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (hram_wr) hram[hram_addr] <= hram_wdata;
    hram_rdata <= hram[hram_addr];
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_rd) evq.push_back('{cyc, 1'b0, mem_addr, 8'h00});
      if (mem_wr) evq.push_back('{cyc, 1'b1, mem_addr, mem_wdata});
      if (dma_done) doneq.push_back(cyc);
      if (dma_active) actq.push_back(cyc);
    end
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a[7:0] ^ a[15:8]) + 8'h5A;
  endfunction

  function automatic int cnt_in(input int q[$], input int lo, input int hi);
    int n = 0;
    foreach (q[i]) if (q[i] > lo && q[i] <= hi) n++;
    return n;
  endfunction

  function automatic int first_in(input int q[$], input int lo, input int hi);
    foreach (q[i]) if (q[i] > lo && q[i] <= hi) return q[i];
    return -1;
  endfunction

  function automatic int last_in(input int q[$], input int lo, input int hi);
    int v = -1;
    foreach (q[i]) if (q[i] > lo && q[i] <= hi) v = q[i];
    return v;
  endfunction

  function automatic int ev_cnt(input int lo, input int hi);
    int n = 0;
    foreach (evq[i]) if (evq[i].cyc > lo && evq[i].cyc <= hi) n++;
    return n;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_set(input logic [15:0] a, input logic [7:0] d, input logic rd, input logic wr);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_rd    = rd;
    cpu_wr    = wr;
  endtask

  task automatic cpu_idle();
    cpu_set(16'h0000, 8'h00, 1'b0, 1'b0);
  endtask

  // Expected 160 alternating read/write pairs starting two cycles after base.
  task automatic verify_seq(input string tag, input int base, input logic [7:0] src);
    int          pos = 0;
    int          errs = 0;
    int          k;
    bit          ew;
    logic [15:0] ea;
    foreach (evq[i]) begin
      if (evq[i].cyc > base && pos < 320) begin
        k  = pos / 2;
        ew = (pos % 2) == 1;
        ea = ew ? (16'hFE00 + 16'(k)) : {src, 8'(k)};
        if (evq[i].cyc != base + 2 + pos || evq[i].wr != ew || evq[i].addr != ea ||
            (ew && evq[i].data != pat({src, 8'(k)})))
          errs++;
        pos++;
      end
    end
    check_eq({tag, "_count"}, pos, 320);
    check_eq({tag, "_seq"}, errs, 0);
  endtask

  initial begin
    int b;
    int b2;
    int r;
    for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
    for (int i = 0; i < 128; i++) hram[i] = 8'h00;
    cpu_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rdata", cpu_rdata, 8'h00);
    check_eq("rst_active", dma_active, 1'b0);
    check_eq("rst_done", dma_done, 1'b0);
    check_eq("rst_mem_rw", {mem_rd, mem_wr}, 2'b00);
    check_eq("rst_mem_addr", mem_addr, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle pass-through of reads and writes
    step(); cpu_set(16'hC105, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("pt_rd_bus", {mem_rd, mem_addr}, {1'b1, 16'hC105});
    step(); cpu_set(16'h8000, 8'h77, 1'b0, 1'b1);
    @(negedge clk);
    check_eq("pt_rdata", cpu_rdata, pat(16'hC105));
    check_eq("pt_wr_bus", {mem_wr, mem_addr, mem_wdata}, {1'b1, 16'h8000, 8'h77});
    step(); cpu_idle();
    @(negedge clk);
    check_eq("pt_mem", mem[16'h8000], 8'h77);
    check_eq("pt_hold", cpu_rdata, pat(16'hC105));

    // Full transfer from page C1 with CPU traffic during DMA
    step(); cpu_set(16'hFF46, 8'hC1, 1'b0, 1'b1); b = cyc;
    for (int c = 1; c <= 340; c++) begin
      step(); cpu_idle();
      case (c)
        10: cpu_set(16'hC000, 8'h00, 1'b1, 1'b0);
        12: cpu_set(16'hC001, 8'h55, 1'b0, 1'b1);
        14: cpu_set(16'hFF90, 8'hA5, 1'b0, 1'b1);
        15: cpu_set(16'hFF90, 8'h00, 1'b1, 1'b0);
        17: cpu_set(16'hFF46, 8'h00, 1'b1, 1'b0);
        default: ;
      endcase
      @(negedge clk);
      case (c)
        1:  check_eq("start_quiet", {dma_active, mem_rd, mem_wr}, 3'b100);
        11: check_eq("blk_rdata", cpu_rdata, 8'hFF);
        12: check_eq("blk_wr_bus", {mem_wr, mem_rd, mem_addr}, {2'b01, 16'hC105});
        14: check_eq("hram_wr", {hram_wr, hram_addr}, {1'b1, 7'h10});
        16: check_eq("hram_rdata", cpu_rdata, 8'hA5);
        18: check_eq("dmareg_rd", cpu_rdata, 8'hC1);
        default: ;
      endcase
    end
    verify_seq("dma1", b, 8'hC1);
    check_eq("dma1_done_n", cnt_in(doneq, b, b + 340), 1);
    check_eq("dma1_done_cyc", first_in(doneq, b, b + 340), b + 322);
    check_eq("dma1_act_n", cnt_in(actq, b, b + 340), 321);
    check_eq("dma1_act_first", first_in(actq, b, b + 340), b + 1);
    check_eq("dma1_act_last", last_in(actq, b, b + 340), b + 321);
    check_eq("blk_mem_kept", mem[16'hC001], pat(16'hC001));
    check_eq("oam_fe05", mem[16'hFE05], pat(16'hC105));

    // Restart at byte 50 with page D0
    step(); cpu_set(16'hFF46, 8'hC1, 1'b0, 1'b1); b = cyc;
    b2 = b + 102;
    for (int c = 1; c <= 450; c++) begin
      step(); cpu_idle();
      if (c == 102) cpu_set(16'hFF46, 8'hD0, 1'b0, 1'b1);
      @(negedge clk);
      if (c == 103) check_eq("rs_start", {dma_active, mem_rd, mem_wr}, 3'b100);
    end
    verify_seq("rs", b2, 8'hD0);
    check_eq("rs_done_n", cnt_in(doneq, b, b + 450), 1);
    check_eq("rs_done_cyc", first_in(doneq, b, b + 450), b2 + 322);

    // Restart coinciding with the final write
    step(); cpu_set(16'hFF46, 8'hC1, 1'b0, 1'b1); b = cyc;
    b2 = b + 321;
    for (int c = 1; c <= 661; c++) begin
      step(); cpu_idle();
      if (c == 321) cpu_set(16'hFF46, 8'hC2, 1'b0, 1'b1);
      @(negedge clk);
      if (c == 321) check_eq("fw_last_wr", {mem_wr, mem_addr}, {1'b1, 16'hFE9F});
    end
    verify_seq("fw_old", b, 8'hC1);
    verify_seq("fw_new", b2, 8'hC2);
    check_eq("fw_done_n", cnt_in(doneq, b, b + 661), 1);
    check_eq("fw_done_cyc", first_in(doneq, b, b + 661), b2 + 322);

    // Echo page E3 reads from C3
    step(); cpu_set(16'hFF46, 8'hE3, 1'b0, 1'b1); b = cyc;
    for (int c = 1; c <= 340; c++) begin
      step(); cpu_idle();
    end
    verify_seq("echo", b, 8'hC3);

    // Reset during byte 10's write
    step(); cpu_set(16'hFF46, 8'hC1, 1'b0, 1'b1); b = cyc;
    for (int c = 1; c <= 23; c++) begin
      step(); cpu_idle();
      if (c == 20) cpu_set(16'hFF46, 8'h00, 1'b1, 1'b0);
      @(negedge clk);
      if (c == 21) check_eq("pre_rst_rdata", cpu_rdata, 8'hC1);
      if (c == 23) check_eq("pre_rst_wr", {mem_wr, mem_addr}, {1'b1, 16'hFE0A});
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_wr", mem_wr, 1'b0);
    check_eq("rst_mid_active", dma_active, 1'b0);
    check_eq("rst_mid_rdata", cpu_rdata, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    r = cyc;
    for (int c = 1; c <= 60; c++) step();
    check_eq("post_rst_ev", ev_cnt(r, r + 60), 0);
    check_eq("post_rst_act", cnt_in(actq, r, r + 60), 0);
    check_eq("post_rst_done", cnt_in(doneq, r, r + 60), 0);
    cpu_set(16'hFF46, 8'h00, 1'b1, 1'b0);
    step(); cpu_idle();
    @(negedge clk);
    check_eq("post_rst_page", cpu_rdata, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
